// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint controller: conditions board run switch and step button,
// gates the datapath clock-enable, and counts executed cycles.
module cpu_run_controller #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int DEB_CYCLES = 250000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_bp_hit;
    logic               w_bp_hit_nxt;
    logic [CNT_W-1:0]   r_cycle_cnt;

    logic               r_run_s1;
    logic               r_run_s2;
    logic               r_run_d;
    logic               r_stp_s1;
    logic               r_stp_s2;
    logic               r_deb;
    logic               r_deb_d;
    logic [DEB_W-1:0]   r_deb_cnt;

    logic               w_run_rise;
    logic               w_step_req;
    logic               w_bp_match;
    logic               w_cpu_en;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_run_d   <= 1'b0;
            r_stp_s1  <= 1'b0;
            r_stp_s2  <= 1'b0;
            r_deb     <= 1'b0;
            r_deb_d   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_run_s1 <= run_sw;
            r_run_s2 <= r_run_s1;
            r_run_d  <= r_run_s2;
            r_stp_s1 <= step_btn;
            r_stp_s2 <= r_stp_s1;
            r_deb_d  <= r_deb;
            // Any sample agreeing with the accepted level restarts the stability count.
            if (r_stp_s2 == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_deb     <= r_stp_s2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    assign w_run_rise = r_run_s2 & ~r_run_d;
    assign w_step_req = r_deb & ~r_deb_d;
    assign w_bp_match = bp_en & (pc == bp_addr);
    assign w_cpu_en   = ((r_state == S_RUN) & ~w_bp_match) | (r_state == S_STEP);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= S_HALT;
            r_bp_hit <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bp_hit <= w_bp_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bp_hit_nxt = r_bp_hit;
        case (r_state)
            S_HALT: begin
                if (w_run_rise) begin
                    w_state_nxt  = S_RUN;
                    w_bp_hit_nxt = 1'b0;
                end else if (w_step_req) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (w_bp_match) begin
                    w_state_nxt  = S_BREAK;
                    w_bp_hit_nxt = 1'b1;
                end else if (!r_run_s2) begin
                    w_state_nxt = S_HALT;
                end
            end
            // Breakpoint compare is deliberately ignored here so a step can leave bp_addr.
            S_STEP: w_state_nxt = S_HALT;
            S_BREAK: begin
                if (w_step_req) begin
                    w_state_nxt = S_STEP;
                end else if (!r_run_s2) begin
                    w_state_nxt = S_HALT;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cycle_cnt <= '0;
        end else if (w_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign cpu_en    = w_cpu_en;
    assign halted    = (r_state == S_HALT) | (r_state == S_BREAK);
    assign bp_hit    = r_bp_hit;
    assign cycle_cnt = r_cycle_cnt;
    assign state     = r_state;

endmodule
